// File: rtl/tlb_op_ctrl_pkg.sv
// Shared op codes, field widths and FSM encoding for the TLB maintenance sequencer.
package tlb_op_ctrl_pkg;

  localparam int IDX_W    = 5;
  localparam int INV_OP_W = 5;
  localparam int ASID_W   = 10;
  localparam int VPN_W    = 19;

  localparam logic [2:0] TLBOP_SRCH = 3'd0;
  localparam logic [2:0] TLBOP_RD   = 3'd1;
  localparam logic [2:0] TLBOP_WR   = 3'd2;
  localparam logic [2:0] TLBOP_FILL = 3'd3;
  localparam logic [2:0] TLBOP_INV  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SRCH,
    ST_SRCH_WAIT,
    ST_EXEC,
    ST_RESP
  } tlb_state_e;

endpackage

// File: rtl/tlb_op_ctrl_rand_gen.sv
// TLBFILL index source: wrapping counter, or a 5-bit LFSR when TLB_RAND_LFSR_EN is defined.
module tlb_rand_gen #(
  parameter int TLBNUM = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hold,
  output logic [4:0] rand_index
);

`ifdef TLB_RAND_LFSR_EN
  if (TLBNUM != 32) begin : g_bad_tlbnum
    $error("tlb_rand_gen: LFSR index source requires TLBNUM == 32");
  end

  // x^5 + x^3 + 1, maximal length, never reaches zero from a nonzero seed
  always_ff @(posedge clk) begin
    if (!rst_n)     rand_index <= 5'b00001;
    else if (!hold) rand_index <= {rand_index[3:0], rand_index[4] ^ rand_index[2]};
  end
`else
  if (TLBNUM < 1 || TLBNUM > 32) begin : g_bad_tlbnum
    $error("tlb_rand_gen: TLBNUM must be in 1..32");
  end

  localparam logic [4:0] LAST = 5'(TLBNUM - 1);

  always_ff @(posedge clk) begin
    if (!rst_n)     rand_index <= '0;
    else if (!hold) rand_index <= (rand_index == LAST) ? 5'd0 : rand_index + 5'd1;
  end
`endif

endmodule

// File: rtl/tlb_op_ctrl.sv
// TLB maintenance op sequencer: one op in flight, registered strobes, TLBSRCH via data port 1.
// Optional: TLB_RAND_LFSR_EN selects an LFSR instead of a counter for the fill index.
module tlb_op_ctrl
  import tlb_op_ctrl_pkg::*;
#(
  parameter int TLBNUM = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [2:0]          req_op,
  input  logic [INV_OP_W-1:0] req_inv_op,
  input  logic [ASID_W-1:0]   req_inv_asid,
  input  logic [VPN_W-1:0]    req_inv_vpn,
  input  logic                flush,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic                resp_found,
  output logic [IDX_W-1:0]    resp_index,
  output logic                dport_stall,
  output logic                srch_sel,
  input  logic                tlb_data_found,
  input  logic [IDX_W-1:0]    tlb_data_index,
  output logic                tlbwr_en,
  output logic                tlbfill_en,
  output logic [IDX_W-1:0]    rand_index,
  output logic                invtlb_en,
  output logic [INV_OP_W-1:0] invtlb_op,
  output logic [ASID_W-1:0]   invtlb_asid,
  output logic [VPN_W-1:0]    invtlb_vpn,
  output logic                tlbrd_valid,
  output logic                refetch
);

  tlb_state_e state;
  logic       accept;
  logic       rand_hold;

  assign req_ready = (state == ST_IDLE) && !flush;
  assign accept    = req_valid && req_ready;
  // Freeze on the edge entering EXEC so the fill strobe sees the index shown at accept.
  assign rand_hold = accept && (req_op != TLBOP_SRCH);

  tlb_rand_gen #(.TLBNUM(TLBNUM)) u_rand (
    .clk        (clk),
    .rst_n      (rst_n),
    .hold       (rand_hold),
    .rand_index (rand_index)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      resp_valid  <= 1'b0;
      resp_found  <= 1'b0;
      resp_index  <= '0;
      dport_stall <= 1'b0;
      srch_sel    <= 1'b0;
      tlbwr_en    <= 1'b0;
      tlbfill_en  <= 1'b0;
      invtlb_en   <= 1'b0;
      tlbrd_valid <= 1'b0;
      refetch     <= 1'b0;
      invtlb_op   <= '0;
      invtlb_asid <= '0;
      invtlb_vpn  <= '0;
    end else begin
      srch_sel    <= 1'b0;
      tlbwr_en    <= 1'b0;
      tlbfill_en  <= 1'b0;
      invtlb_en   <= 1'b0;
      tlbrd_valid <= 1'b0;
      refetch     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            invtlb_op   <= req_inv_op;
            invtlb_asid <= req_inv_asid;
            invtlb_vpn  <= req_inv_vpn;
            resp_found  <= 1'b0;
            resp_index  <= '0;
            if (req_op == TLBOP_SRCH) begin
              state       <= ST_SRCH;
              srch_sel    <= 1'b1;
              dport_stall <= 1'b1;
            end else begin
              // Strobes are registered here so they are high exactly during EXEC.
              state <= ST_EXEC;
              case (req_op)
                TLBOP_RD:   tlbrd_valid <= 1'b1;
                TLBOP_WR:   begin tlbwr_en   <= 1'b1; refetch <= 1'b1; end
                TLBOP_FILL: begin tlbfill_en <= 1'b1; refetch <= 1'b1; end
                TLBOP_INV:  begin invtlb_en  <= 1'b1; refetch <= 1'b1; end
                default: ;
              endcase
            end
          end
        end
        ST_SRCH: state <= ST_SRCH_WAIT;
        ST_SRCH_WAIT: begin
          dport_stall <= 1'b0;
          resp_found  <= tlb_data_found;
          resp_index  <= tlb_data_found ? tlb_data_index : '0;
          resp_valid  <= 1'b1;
          state       <= ST_RESP;
        end
        ST_EXEC: begin
          resp_valid <= 1'b1;
          state      <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Scoreboard bench for tlb_op_ctrl: timed driver pushes expectations, negedge monitor compares.
module tb_tlb_op_ctrl;

  localparam int TLBNUM = 32;

  logic        clk = 1'b0;
  logic        rst_n, req_valid, req_ready, flush;
  logic [2:0]  req_op;
  logic [4:0]  req_inv_op;
  logic [9:0]  req_inv_asid;
  logic [18:0] req_inv_vpn;
  logic        resp_valid, resp_ready, resp_found;
  logic [4:0]  resp_index;
  logic        dport_stall, srch_sel, tlb_data_found;
  logic [4:0]  tlb_data_index;
  logic        tlbwr_en, tlbfill_en, invtlb_en, tlbrd_valid, refetch;
  logic [4:0]  rand_index, invtlb_op;
  logic [9:0]  invtlb_asid;
  logic [18:0] invtlb_vpn;

  always #5 clk = ~clk;

  tlb_op_ctrl #(.TLBNUM(TLBNUM)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_inv_op(req_inv_op), .req_inv_asid(req_inv_asid),
    .req_inv_vpn(req_inv_vpn), .flush(flush), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_found(resp_found), .resp_index(resp_index),
    .dport_stall(dport_stall), .srch_sel(srch_sel), .tlb_data_found(tlb_data_found),
    .tlb_data_index(tlb_data_index), .tlbwr_en(tlbwr_en), .tlbfill_en(tlbfill_en),
    .rand_index(rand_index), .invtlb_en(invtlb_en), .invtlb_op(invtlb_op),
    .invtlb_asid(invtlb_asid), .invtlb_vpn(invtlb_vpn), .tlbrd_valid(tlbrd_valid),
    .refetch(refetch)
  );

  // strobe vector layout: {srch_sel, tlbrd_valid, tlbwr_en, tlbfill_en, invtlb_en, refetch}
  typedef struct {int cyc; logic [5:0] vec; logic [4:0] iop; logic [9:0] asid; logic [18:0] vpn;} strb_t;
  typedef struct {int cyc; logic found; logic [4:0] idx;} resp_t;

  strb_t sq[$];
  resp_t rq[$];
  strb_t se;
  resp_t re;
  int    cyc = 0, n_cmp = 0, n_bad = 0, stall_left = 0;
  bit    mon_en = 0, drv_idle = 1, resp_seen = 0;
  logic [4:0] exp_rand;

  always @(posedge clk) cyc <= cyc + 1;

`ifdef TLB_RAND_LFSR_EN
  localparam logic [4:0] RAND_SEED = 5'd1;
  function automatic logic [4:0] rand_next(input logic [4:0] r);
    return {r[3:0], r[4] ^ r[2]};
  endfunction
`else
  localparam logic [4:0] RAND_SEED = 5'd0;
  function automatic logic [4:0] rand_next(input logic [4:0] r);
    return 5'((int'(r) + 1) % TLBNUM);
  endfunction
`endif

  // Reference for the fill index: advances each edge except the one accepting a non-SRCH op.
  always @(posedge clk) begin
    if (!rst_n) exp_rand <= RAND_SEED;
    else if (!(drv_idle && req_valid && !flush && req_op != 3'd0)) exp_rand <= rand_next(exp_rand);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("req_ready", 32'(req_ready), 32'(drv_idle && !flush));
      check("rand_index", 32'(rand_index), 32'(exp_rand));
      if (srch_sel || tlbrd_valid || tlbwr_en || tlbfill_en || invtlb_en || refetch) begin
        if (sq.size() == 0) begin
          check("unexpected_strobe", {26'd0, srch_sel, tlbrd_valid, tlbwr_en, tlbfill_en, invtlb_en, refetch}, 32'd0);
        end else begin
          se = sq.pop_front();
          check("strobe_set", {26'd0, srch_sel, tlbrd_valid, tlbwr_en, tlbfill_en, invtlb_en, refetch}, 32'(se.vec));
          check("strobe_cycle", 32'(cyc), 32'(se.cyc));
          if (se.vec[1]) begin
            check("invtlb_op", 32'(invtlb_op), 32'(se.iop));
            check("invtlb_asid", 32'(invtlb_asid), 32'(se.asid));
            check("invtlb_vpn", 32'(invtlb_vpn), 32'(se.vpn));
          end
          if (se.vec[5]) stall_left = 2;
        end
      end
      check("dport_stall", 32'(dport_stall), 32'(stall_left > 0));
      if (stall_left > 0) stall_left--;
      if (resp_valid) begin
        if (rq.size() == 0) begin
          check("unexpected_resp", 32'(resp_valid), 32'd0);
        end else begin
          re = rq[0];
          if (!resp_seen) check("resp_cycle", 32'(cyc), 32'(re.cyc));
          resp_seen = 1;
          check("resp_found", 32'(resp_found), 32'(re.found));
          check("resp_index", 32'(resp_index), 32'(re.idx));
          if (resp_ready) begin
            void'(rq.pop_front());
            resp_seen = 0;
          end
        end
      end
    end
  end

  // Called at #1 after an edge with the DUT idle; returns at #1 after the edge ending the op.
  task automatic run_op(input logic [2:0] op, input logic [4:0] iop, input logic [9:0] asid,
                        input logic [18:0] vpn, input bit fnd, input int nflush, input int rdly,
                        input bit rst_mid);
    logic [4:0] idx;
    logic [5:0] vec;
    int c, lat, h, last;
    idx = 5'($urandom);
    req_valid = 1; req_op = op; req_inv_op = iop; req_inv_asid = asid; req_inv_vpn = vpn;
    resp_ready = 0;
    repeat (nflush) begin flush = 1; @(posedge clk); #1; end
    flush = 0;
    c   = cyc;
    lat = (op == 3'd0) ? 3 : 2;
    h   = c + lat + rdly;
    case (op)
      3'd0: vec = 6'b100000;
      3'd1: vec = 6'b010000;
      3'd2: vec = 6'b001001;
      3'd3: vec = 6'b000101;
      3'd4: vec = 6'b000011;
      default: vec = 6'b000000;
    endcase
    if (vec != 0) sq.push_back('{c + 1, vec, iop, asid, vpn});
    if (!rst_mid) rq.push_back('{c + lat, (op == 3'd0) && fnd, ((op == 3'd0) && fnd) ? idx : 5'd0});
    @(posedge clk); #1;
    drv_idle = 0; req_valid = 0; req_op = 3'($urandom);
    req_inv_op = 5'($urandom); req_inv_asid = 10'($urandom); req_inv_vpn = 19'($urandom);
    last = rst_mid ? c + 2 : h;
    for (int k = c + 1; k <= last; k++) begin
      flush          = ($urandom_range(0, 3) == 0);
      tlb_data_found = (k == c + 2) ? fnd : 1'($urandom);
      tlb_data_index = (k == c + 2) ? idx : 5'($urandom);
      resp_ready     = (k == h) ? 1'b1 : (k < c + lat) ? 1'($urandom) : 1'b0;
      if (rst_mid && k == c + 2) rst_n = 0;
      @(posedge clk); #1;
    end
    rst_n = 1; resp_ready = 0; flush = 0; drv_idle = 1;
  endtask

  initial begin
    rst_n = 0; req_valid = 1; flush = 0; resp_ready = 0; req_op = 3'd2;
    req_inv_op = 0; req_inv_asid = 0; req_inv_vpn = 0; tlb_data_found = 0; tlb_data_index = 0;
    @(posedge clk); #1;
    mon_en = 1;
    @(posedge clk); #1;
    rst_n = 1; req_valid = 0;
    repeat (2) @(posedge clk);
    #1;

    run_op(3'd0, 5'd0, 10'd0, 19'd0, 1'b1, 0, 0, 1'b0);       // SRCH hit
    run_op(3'd0, 5'd0, 10'd0, 19'd0, 1'b0, 0, 1, 1'b0);       // SRCH miss
    run_op(3'd3, 5'd0, 10'd0, 19'd0, 1'b0, 0, 0, 1'b0);       // FILL
    run_op(3'd4, 5'd5, 10'h3, 19'h1234, 1'b0, 0, 4, 1'b0);    // INV, slow consumer
    run_op(3'd2, 5'd0, 10'd0, 19'd0, 1'b0, 2, 0, 1'b0);       // WR behind IDLE flush
    run_op(3'd0, 5'd0, 10'd0, 19'd0, 1'b1, 0, 0, 1'b1);       // SRCH killed by reset
    run_op(3'd1, 5'd0, 10'd0, 19'd0, 1'b0, 0, 0, 1'b0);       // RD
    run_op(3'd6, 5'd0, 10'd0, 19'd0, 1'b0, 0, 0, 1'b0);       // illegal

    for (int i = 0; i < 80; i++) begin
      run_op(3'($urandom_range(0, 7)), 5'($urandom), 10'($urandom), 19'($urandom),
             1'($urandom), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0,
             $urandom_range(0, 3), 1'b0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (5) @(posedge clk);
    #1;
    check("strobe_queue_drained", 32'(sq.size()), 32'd0);
    check("resp_queue_drained", 32'(rq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
